// File: rtl/spi_adc_scanner_pkg.sv
// Shared types and constants for the SPI ADC scanner: FSM encoding,
// MCP320x-style command framing and the frame-length helper.
package spi_adc_scanner_pkg;

  // Command field: start bit, single-ended bit, 3-bit channel number.
  localparam int CMD_BITS  = 5;
  // One null bit precedes the data on MISO.
  localparam int NULL_BITS = 1;
  // Channel field width on the wire and on the result stream.
  localparam int CH_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_OUT      = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // SCK periods per conversion frame.
  function automatic int frame_len(input int data_w);
    return CMD_BITS + NULL_BITS + data_w;
  endfunction

  // MOSI bit for a given bit slot of the frame: 1, 1, ch[2:0], then zeros.
  function automatic logic cmd_bit(input int idx, input logic [CH_W-1:0] ch);
    logic b;
    case (idx)
      0, 1:    b = 1'b1;
      2:       b = ch[2];
      3:       b = ch[1];
      4:       b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_adc_scanner_if.sv
// SPI pins and result stream of the scanner, bundled for port connection.
//
// Result stream handshake: a transfer happens on a clk edge where
// o_valid & i_ready are both high; while o_valid & !i_ready, o_data and
// o_ch hold their values and o_valid never drops without a transfer.
interface spi_adc_scanner_if
  import spi_adc_scanner_pkg::*;
#(
  parameter int DATA_W = 12
);
  logic              sck;
  logic              mosi;
  logic              cs_n;
  logic              miso;
  logic [DATA_W-1:0] o_data;
  logic [CH_W-1:0]   o_ch;
  logic              o_valid;
  logic              i_ready;

  // Scanner side: drives the SPI pins and the result stream.
  modport master (
    output sck, mosi, cs_n, o_data, o_ch, o_valid,
    input  miso, i_ready
  );

  // ADC / consumer side.
  modport slave (
    input  sck, mosi, cs_n, o_data, o_ch, o_valid,
    output miso, i_ready
  );
endinterface

// File: rtl/spi_adc_scanner_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV clk cycles.
// Each tick marks an SCK half-period boundary.
module spi_tick_gen
  import spi_adc_scanner_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_adc_scanner.sv
// Round-robin multi-channel SPI ADC front end (MCP320x-style framing).
// Scans N_CH channels, returns each result with its channel tag on a
// valid/ready stream and keeps one over-threshold flag per channel.
module spi_adc_scanner
  import spi_adc_scanner_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int N_CH    = 4,
  parameter int CLK_DIV = 2,
  parameter int THRESH  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              i_mode,
  input  logic              i_start,
  spi_adc_scanner_if.master bus,
  output logic [N_CH-1:0]   o_over,
  output logic              o_busy,
  output state_t            fsm_state
);
  localparam int          FRAME    = frame_len(DATA_W);
  localparam int          RC_W     = $clog2(FRAME + 1);
  localparam logic [31:0] THRESH_L = THRESH;

  logic              tick;
  state_t            state;
  logic [RC_W-1:0]   rise_cnt;    // SCK rising edges issued in this frame
  logic              gap_cnt;     // first/second half-period of GAP
  logic [CH_W-1:0]   ptr;         // channel of the current/next frame
  logic [DATA_W-1:0] shreg;       // last DATA_W MISO samples
  logic              start_pend;  // single-shot trigger seen while idle

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Frame sequencer, SPI pin drivers, capture shifter and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rise_cnt    <= '0;
      gap_cnt     <= 1'b0;
      ptr         <= '0;
      shreg       <= '0;
      start_pend  <= 1'b0;
      bus.cs_n    <= 1'b1;
      bus.sck     <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.o_data  <= '0;
      bus.o_ch    <= '0;
      bus.o_valid <= 1'b0;
      o_over      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ena && i_start) begin
            start_pend <= 1'b1;
          end
          if (tick && ena && (i_mode || start_pend || i_start)) begin
            state      <= ST_CS_SETUP;
            start_pend <= 1'b0;
            bus.cs_n   <= 1'b0;
            bus.mosi   <= cmd_bit(0, ptr);
          end
        end

        ST_CS_SETUP: begin
          if (tick) begin
            state    <= ST_SHIFT;
            bus.sck  <= 1'b1;
            rise_cnt <= RC_W'(1);
            shreg    <= {shreg[DATA_W-2:0], bus.miso};
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            if (bus.sck) begin
              // Falling edge: present the next command bit.
              bus.sck  <= 1'b0;
              bus.mosi <= cmd_bit(int'(rise_cnt), ptr);
            end else if (rise_cnt == RC_W'(FRAME)) begin
              state <= ST_CS_HOLD;
            end else begin
              // Rising edge: sample MISO; older bits fall off the top.
              bus.sck  <= 1'b1;
              rise_cnt <= rise_cnt + RC_W'(1);
              shreg    <= {shreg[DATA_W-2:0], bus.miso};
            end
          end
        end

        ST_CS_HOLD: begin
          if (tick) begin
            state    <= ST_OUT;
            bus.cs_n <= 1'b1;
          end
        end

        ST_OUT: begin
          // o_valid is low only on the entry cycle, since accepting a
          // result leaves this state in the same edge.
          if (!bus.o_valid) begin
            bus.o_data  <= shreg;
            bus.o_ch    <= ptr;
            bus.o_valid <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              if (ptr == CH_W'(i)) begin
                o_over[i] <= (32'(shreg) >= THRESH_L);
              end
            end
          end else if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            ptr         <= (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + CH_W'(1);
            state       <= ST_GAP;
            gap_cnt     <= 1'b0;
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (!gap_cnt) begin
              gap_cnt <= 1'b1;
            end else if (ena && i_mode) begin
              state    <= ST_CS_SETUP;
              bus.cs_n <= 1'b0;
              bus.mosi <= cmd_bit(0, ptr);
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = !bus.cs_n || bus.o_valid;
  assign fsm_state = state;

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: behavioural per-channel ADC, cycle monitor
// with a channel/threshold model, and directed scenarios.
module tb_spi_adc_scanner;
  import spi_adc_scanner_pkg::*;

  localparam int DATA_W  = 12;
  localparam int N_CH    = 4;
  localparam int CLK_DIV = 2;
  localparam int THRESH  = 2048;
  localparam int FRAME   = 6 + DATA_W;                 // 18 SCK periods
  localparam int CS_LOW  = (2 + 2 * FRAME) * CLK_DIV;  // 76 clk cycles

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic i_mode = 1'b0;
  logic i_start = 1'b0;
  logic [N_CH-1:0] o_over;
  logic o_busy;
  state_t fsm_state;
  logic rst_q = 1'b0;

  spi_adc_scanner_if #(.DATA_W(DATA_W)) bus ();

  spi_adc_scanner #(
    .DATA_W(DATA_W), .N_CH(N_CH), .CLK_DIV(CLK_DIV), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .i_mode(i_mode), .i_start(i_start),
    .bus(bus), .o_over(o_over), .o_busy(o_busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst_n;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC + output model ----------------
  logic [DATA_W-1:0] adc_val [N_CH] = '{12'hA5C, 12'h123, 12'h800, 12'h7FF};

  logic [DATA_W-1:0] exp_q [$];   // expected result data, in acceptance order
  logic [4:0]        cmd_q [$];
  logic [2:0]        acc_ch_q [$];
  logic [DATA_W-1:0] acc_data_q [$];

  int exp_ch = 0;
  logic [N_CH-1:0] exp_over = '0;
  logic [4:0] cmd = '0;
  int rise_k = 0;
  int cs_low_len = 0;
  int hi_len = 0;
  int lo_len = 0;
  int cs_age = 99;
  int frames_started = 0;
  logic in_frame = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_sck = 1'b0;
  logic prev_valid = 1'b0;
  logic acc_pending = 1'b0;
  logic [DATA_W-1:0] held_data = '0;
  logic [2:0] held_ch = '0;

  // ADC output bit for rising edge k: ones over command/null slots, then data MSB first.
  function automatic logic adc_bit(input int k);
    int ch;
    ch = int'(cmd[2:0]);
    if (k <= 6) return 1'b1;
    if (k > FRAME || ch >= N_CH) return 1'b0;
    return adc_val[ch][DATA_W - 1 - (k - 7)];
  endfunction

  // Monitor, ADC model and scoreboard, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst_q) begin
      check("rst_cs_n",    32'(bus.cs_n), 1);
      check("rst_sck",     32'(bus.sck), 0);
      check("rst_mosi",    32'(bus.mosi), 0);
      check("rst_o_valid", 32'(bus.o_valid), 0);
      check("rst_o_data",  32'(bus.o_data), 0);
      check("rst_o_ch",    32'(bus.o_ch), 0);
      check("rst_o_over",  32'(o_over), 0);
      check("rst_busy",    32'(o_busy), 0);
      exp_ch = 0; exp_over = '0; rise_k = 0; in_frame = 1'b0; cs_age = 99;
      frames_started = 0; acc_pending = 1'b0;
      prev_cs = 1'b1; prev_sck = 1'b0; prev_valid = 1'b0;
      exp_q.delete();
      bus.miso = 1'b0;
    end else begin
      check("o_busy", 32'(o_busy), 32'(!bus.cs_n || bus.o_valid));
      if (acc_pending) check("valid_drop_after_accept", 32'(bus.o_valid), 0);
      acc_pending = 1'b0;
      if (bus.cs_n) check("sck_idle_low", 32'(bus.sck), 0);

      // frame start
      if (prev_cs && !bus.cs_n) begin
        check("no_frame_while_valid", 32'(bus.o_valid), 0);
        frames_started++;
        in_frame = 1'b1; cs_low_len = 0; rise_k = 0; cmd = '0;
        hi_len = 0; lo_len = 0;
        bus.miso = adc_bit(1);
      end
      if (!bus.cs_n) cs_low_len++;

      // SCK edges
      if (!prev_sck && bus.sck) begin
        rise_k++;
        if (rise_k > 1) check("sck_low_clks", 32'(lo_len), CLK_DIV);
        hi_len = 0;
        if (rise_k <= 5) cmd = {cmd[3:0], bus.mosi};
      end
      if (prev_sck && !bus.sck) begin
        check("sck_high_clks", 32'(hi_len), CLK_DIV);
        lo_len = 0;
        bus.miso = adc_bit(rise_k + 1);
      end
      if (bus.sck) hi_len++; else lo_len++;

      // frame end
      if (!prev_cs && bus.cs_n && in_frame) begin
        check("cs_low_clks", 32'(cs_low_len), CS_LOW);
        check("sck_rises",   32'(rise_k), FRAME);
        check("mosi_cmd",    32'(cmd), 32'({2'b11, 3'(exp_ch)}));
        cmd_q.push_back(cmd);
        exp_q.push_back(adc_val[exp_ch]);
        in_frame = 1'b0;
        cs_age = 0;
      end else if (cs_age < 99) begin
        cs_age++;
      end

      // result stream
      if (cs_age == 1) check("valid_rise_1clk_after_cs", 32'(bus.o_valid && !prev_valid), 1);
      if (bus.o_valid && !prev_valid) begin
        check("valid_rise_age", 32'(cs_age), 1);
        exp_over[exp_ch] = (32'(adc_val[exp_ch]) >= 32'(THRESH));
        check("o_ch", 32'(bus.o_ch), 32'(exp_ch));
        if (exp_q.size() > 0) check("o_data", 32'(bus.o_data), 32'(exp_q[0]));
        else check("o_data_unexpected", 32'(exp_q.size()), 1);
        held_data = bus.o_data; held_ch = bus.o_ch;
      end else if (bus.o_valid) begin
        check("o_data_stable", 32'(bus.o_data), 32'(held_data));
        check("o_ch_stable",   32'(bus.o_ch), 32'(held_ch));
      end
      check("o_over", 32'(o_over), 32'(exp_over));

      if (bus.o_valid && bus.i_ready && rst_n) begin
        acc_ch_q.push_back(bus.o_ch);
        acc_data_q.push_back(bus.o_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_ch = (exp_ch + 1) % N_CH;
        acc_pending = 1'b1;
      end

      prev_cs = bus.cs_n; prev_sck = bus.sck; prev_valid = bus.o_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    acc_ch_q.delete(); acc_data_q.delete(); cmd_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int t;
    t = 0;
    while (acc_ch_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("wait_accept_count", 32'(acc_ch_q.size() >= n), 1);
  endtask

  task automatic check_acc(input int i, input int ch, input logic [31:0] data);
    if (acc_ch_q.size() > i) begin
      check("acc_ch",   32'(acc_ch_q[i]), 32'(ch));
      check("acc_data", 32'(acc_data_q[i]), data);
    end else begin
      check("acc_present", 32'(acc_ch_q.size()), 32'(i + 1));
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t;
    bus.i_ready = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    acc_ch_q.delete(); acc_data_q.delete(); cmd_q.delete();
    cycles(5);
    check("idle_no_frame", 32'(frames_started), 0);

    // Continuous scan with a always-ready consumer.
    i_mode = 1'b1; ena = 1'b1;
    wait_acc(5, 1200);
    ena = 1'b0;
    check_acc(0, 0, 'hA5C);
    check_acc(1, 1, 'h123);
    check_acc(2, 2, 'h800);
    check_acc(3, 3, 'h7FF);
    check_acc(4, 0, 'hA5C);
    if (cmd_q.size() >= 5) begin
      check("cmd0", 32'(cmd_q[0]), 'b11000);
      check("cmd1", 32'(cmd_q[1]), 'b11001);
      check("cmd2", 32'(cmd_q[2]), 'b11010);
      check("cmd3", 32'(cmd_q[3]), 'b11011);
      check("cmd4", 32'(cmd_q[4]), 'b11000);
    end else begin
      check("cmd_count", 32'(cmd_q.size()), 5);
    end
    check("over_after_scan", 32'(o_over), 'b0101);
    cycles(60);
    check("frames_after_ena_off", 32'(frames_started), 5);

    // Backpressure: consumer stalls for 200 cycles on the first result.
    bus.i_ready = 1'b0;
    do_reset();
    ena = 1'b1; i_mode = 1'b1;
    t = 0;
    while (!bus.o_valid && t < 300) begin @(posedge clk); t++; end
    #1;
    check("bp_valid_seen", 32'(bus.o_valid), 1);
    cycles(200);
    check("bp_data_held",  32'(bus.o_data), 'hA5C);
    check("bp_ch_held",    32'(bus.o_ch), 0);
    check("bp_cs_high",    32'(bus.cs_n), 1);
    check("bp_no_new_frame", 32'(frames_started), 1);
    bus.i_ready = 1'b1;
    wait_acc(2, 400);
    ena = 1'b0;
    check_acc(0, 0, 'hA5C);
    check_acc(1, 1, 'h123);
    cycles(60);

    // Single-shot triggers; a trigger during a frame is ignored.
    do_reset();
    i_mode = 1'b0; ena = 1'b1;
    cycles(20);
    check("ss_no_frame_without_start", 32'(frames_started), 0);
    pulse_start();
    wait_acc(1, 300);
    cycles(100);
    check("ss_one_frame", 32'(frames_started), 1);
    check_acc(0, 0, 'hA5C);
    pulse_start();
    wait_acc(2, 300);
    cycles(100);
    check("ss_second_frame", 32'(frames_started), 2);
    check_acc(1, 1, 'h123);
    pulse_start();
    cycles(30);
    check("ss_in_frame", 32'(bus.cs_n), 0);
    pulse_start();
    wait_acc(3, 300);
    cycles(150);
    check("ss_pulse_in_shift_ignored", 32'(frames_started), 3);
    check_acc(2, 2, 'h800);
    ena = 1'b0;

    // Reset in the middle of a frame, then rescan from channel 0.
    do_reset();
    i_mode = 1'b1; ena = 1'b1;
    t = 0;
    while (!(bus.cs_n == 1'b0 && rise_k == 5) && t < 500) begin @(negedge clk); t++; end
    check("reach_bit5", 32'(rise_k), 5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_cs_n", 32'(bus.cs_n), 1);
    check("midrst_valid", 32'(bus.o_valid), 0);
    acc_ch_q.delete(); acc_data_q.delete(); cmd_q.delete();
    wait_acc(1, 300);
    check_acc(0, 0, 'hA5C);

    // Drop ena during the ch2 frame, then resume with ch3 and wrap to ch0.
    t = 0;
    while (!(bus.cs_n == 1'b0 && exp_ch == 2 && rise_k == 8) && t < 1000) begin
      @(negedge clk); t++;
    end
    check("reach_ch2_frame", 32'(exp_ch), 2);
    @(posedge clk); #1 ena = 1'b0;
    wait_acc(3, 300);
    check_acc(2, 2, 'h800);
    cycles(200);
    check("ena_off_idle_cs", 32'(bus.cs_n), 1);
    check("ena_off_frames", 32'(frames_started), 3);
    ena = 1'b1;
    wait_acc(5, 400);
    ena = 1'b0;
    check_acc(3, 3, 'h7FF);
    check_acc(4, 0, 'hA5C);
    cycles(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
